// File: rtl/seq_shift_add_mult32.sv
// Purpose : unsigned NxN -> 2N sequential shift-add multiplier driving an external adder.
// Latency : out_valid rises 32 cycles after acceptance; the next operand pair can be taken 34 cycles after the last one at the earliest.
// Backpres: in_ready is low while busy; DONE holds out_product stable until out_ready.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready, in_a, in_b   operand handshake (multiplicand, multiplier)
//   out_valid/out_ready, out_product registered 2N-bit product handshake
//   add_a, add_b, add_cin           operands driven to the external adder
//   add_sum, add_cout               combinational return from the external adder
module seq_shift_add_mult32 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_sum,
    input  logic           add_cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   out_product_q, out_product_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mcand_q       <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            acc_hi_q      <= acc_hi_d;
            acc_lo_q      <= acc_lo_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mcand_d       = mcand_q;
        acc_hi_d      = acc_hi_q;
        acc_lo_d      = acc_lo_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        add_a         = '0;
        add_b         = '0;
        add_cin       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = in_a;
                    acc_lo_d = in_b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                add_a = acc_hi_q;
                add_b = acc_lo_q[0] ? mcand_q : '0;
                // The carry-out becomes the top bit of the shifted accumulator,
                // so the full N+1-bit partial sum is kept every iteration.
                {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_product_d = {acc_hi_d, acc_lo_d};
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is a pure function of state: no path from in_valid or out_ready.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

endmodule

// File: tb/tb_seq_shift_add_mult32.sv
module tb_seq_shift_add_mult32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    seq_shift_add_mult32 #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout)
    );

    // External adder stand-in: full 33-bit sum.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    logic [63:0] exp_q[$];
    int          acc_q[$];
    int          n_in = 0;
    int          n_out = 0;
    logic [31:0] cur_a = '0;
    logic [63:0] last_prod = '0;
    logic [63:0] prev_prod = '0;
    logic        prev_ov = 1'b0;
    logic        post_xfer = 1'b0;
    logic        chk_b0 = 1'b0;
    logic        rnd_rdy = 1'b0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov   = 1'b0;
            post_xfer = 1'b0;
        end else begin
            check("add_cin_zero", 64'(add_cin), 64'd0);
            if (post_xfer) begin
                check("in_ready_after_xfer", 64'(in_ready), 64'd1);
                check("product_hold_after_xfer", out_product, last_prod);
                post_xfer = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(64'(in_a) * 64'(in_b));
                acc_q.push_back(cyc + 1);
                cur_a = in_a;
                n_in++;
            end
            if (!in_ready && !out_valid) begin
                check("add_b_is_0_or_mcand", 64'((add_b == 32'd0) || (add_b == cur_a)), 64'd1);
                if (chk_b0) check("add_b_zero_b0", 64'(add_b), 64'd0);
            end else begin
                check("adder_idle_zero", {add_a, add_b}, 64'd0);
            end
            if (out_valid) begin
                check("in_ready_low_done", 64'(in_ready), 64'd0);
                if (!prev_ov) begin
                    if (acc_q.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
                    else check("latency", 64'(cyc - acc_q.pop_front()), 64'd32);
                end else begin
                    check("product_stable", out_product, prev_prod);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) check("product_unexpected", out_product, 64'hx);
                    else check("product", out_product, exp_q.pop_front());
                    last_prod = out_product;
                    n_out++;
                    post_xfer = 1'b1;
                end
            end
            prev_ov   = out_valid;
            prev_prod = out_product;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int k;
        @(posedge clk);
        #1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 200) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (n_out >= target) break;
        end
        if (k == 500) check("output_timeout", 64'(n_out), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_product", out_product, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_adder", {add_a, add_b}, 64'd0);
        check("rst_add_cin", 64'(add_cin), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Small product with immediate acceptance.
        run_op(32'd3, 32'd5);
        wait_out(n_out + 1);
        check("dir_3x5", last_prod, 64'h0000_0000_0000_000F);

        // Carry-out used on every iteration.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_out(n_out + 1);
        check("dir_max", last_prod, 64'hFFFF_FFFE_0000_0001);

        // Zero multiplier: adder operand y must stay zero throughout.
        chk_b0 = 1'b1;
        run_op(32'h1234_5678, 32'd0);
        wait_out(n_out + 1);
        chk_b0 = 1'b0;
        check("dir_b0", last_prod, 64'd0);
        run_op(32'd0, 32'h9ABC_DEF0);
        wait_out(n_out + 1);
        check("dir_a0", last_prod, 64'd0);

        // Consumer stall with in_valid pulses that must be ignored.
        out_ready = 1'b0;
        run_op(32'h8000_0000, 32'd2);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            if (k == 200) check("stall_valid_timeout", 64'd1, 64'd0);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_a = $urandom;
            in_b = $urandom;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_product", out_product, 64'h0000_0001_0000_0000);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out(n_out + 1);

        // Reset in the middle of a run discards the operation.
        run_op(32'd7, 32'd9);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_product", out_product, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_adder", {add_a, add_b}, 64'd0);
        exp_q.delete();
        acc_q.delete();
        n_in = n_out;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(32'd6, 32'd7);
        wait_out(n_out + 1);
        check("after_rst_6x7", last_prod, 64'd42);

        // Back-to-back random traffic, in_valid held high, random stalls.
        rnd_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int k;
            in_a = (i % 17 == 0) ? 32'hFFFF_FFFF : $urandom;
            in_b = (i % 23 == 0) ? 32'hFFFF_FFFF : $urandom;
            for (k = 0; k < 500; k++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            if (k == 500) check("rand_accept_timeout", 64'd1, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_out(n_in);
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("handshake_count", 64'(n_out), 64'(n_in));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
